// File: rtl/warn_sensor_array.sv
// warn_sensor_array: per-channel threshold monitors with debounce, hysteresis
// release and optional ack latching, plus a global OR and a saturating event count.

// One monitored channel: condition evaluation and the debounce/latch FSM.
module warn_sensor_chan #(
    parameter int WIDTH    = 32,
    parameter int DEBOUNCE = 4,
    parameter int HYST     = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] sensor,
    input  logic signed [WIDTH-1:0] threshold,
    input  logic                    mode,
    input  logic                    latch_en,
    input  logic                    ack,
    output logic                    warn_d,
    output logic                    warn_q
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int XW = WIDTH + 2;
    localparam logic [CW-1:0]        CNT_MAX = CW'(DEBOUNCE);
    localparam logic signed [XW-1:0] HYST_X  = XW'(HYST);

    typedef enum logic [2:0] {S_OK, S_PEND, S_WARN, S_REL, S_HOLD} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [XW-1:0] sen_x, thr_x;
    logic                 bad, clr, release_now;

    // Widen both operands by two bits so threshold +/- HYST never wraps.
    always_comb begin
        sen_x = {{2{sensor[WIDTH-1]}}, sensor};
        thr_x = {{2{threshold[WIDTH-1]}}, threshold};
        if (mode) begin
            bad = sen_x > thr_x;
            clr = sen_x <= (thr_x - HYST_X);
        end else begin
            bad = sen_x < thr_x;
            clr = sen_x >= (thr_x + HYST_X);
        end
    end

    // State, debounce counter and registered warn.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_OK;
            cnt_q   <= '0;
            warn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            warn_q  <= warn_d;
        end
    end

    // Next state: debounce into WARN, debounce out through REL, optional HOLD.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        release_now = 1'b0;
        case (state_q)
            S_OK: begin
                cnt_d = '0;
                if (bad) begin
                    if (DEBOUNCE == 1) begin
                        state_d = S_WARN;
                    end else begin
                        state_d = S_PEND;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_PEND: begin
                if (!bad) begin
                    state_d = S_OK;
                    cnt_d   = '0;
                end else if (cnt_q + CW'(1) == CNT_MAX) begin
                    state_d = S_WARN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WARN: begin
                cnt_d = '0;
                if (clr) begin
                    if (DEBOUNCE == 1) begin
                        release_now = 1'b1;
                    end else begin
                        state_d = S_REL;
                        cnt_d   = CW'(1);
                    end
                end
            end
            S_REL: begin
                if (!clr) begin
                    state_d = S_WARN;
                    cnt_d   = '0;
                end else if (cnt_q + CW'(1) == CNT_MAX) begin
                    release_now = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                cnt_d = '0;
                if (ack) state_d = clr ? S_OK : S_WARN;
            end
            default: begin
                state_d = S_OK;
                cnt_d   = '0;
            end
        endcase
        // latch_en only matters at the instant the release completes
        if (release_now) begin
            cnt_d   = '0;
            state_d = latch_en ? S_HOLD : S_OK;
        end
    end

    // Warn is high in every state past the assert debounce.
    always_comb begin
        warn_d = (state_d == S_WARN) || (state_d == S_REL) || (state_d == S_HOLD);
    end
endmodule

module warn_sensor_array #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int DEBOUNCE = 4,
    parameter int HYST     = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] sensor,
    input  logic [CHANNELS*WIDTH-1:0] threshold,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS-1:0]       latch_en,
    input  logic [CHANNELS-1:0]       ack,
    output logic [CHANNELS-1:0]       warn,
    output logic                      any_warn,
    output logic [CNT_W-1:0]          event_count
);
    localparam int SW = CNT_W + $clog2(CHANNELS + 1);
    localparam logic [SW-1:0] SAT = {{(SW-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [CHANNELS-1:0] warn_d, warn_q;
    logic                any_warn_q, any_warn_d;
    logic [CNT_W-1:0]    event_count_q, event_count_d;
    logic [SW-1:0]       sum;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        warn_sensor_chan #(
            .WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .HYST(HYST)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .sensor   (sensor[i*WIDTH +: WIDTH]),
            .threshold(threshold[i*WIDTH +: WIDTH]),
            .mode     (mode[i]),
            .latch_en (latch_en[i]),
            .ack      (ack[i]),
            .warn_d   (warn_d[i]),
            .warn_q   (warn_q[i])
        );
    end

    // Global flag from next-state warns; count every 0->1 rise, saturating.
    always_comb begin
        any_warn_d = |warn_d;
        sum        = SW'(event_count_q);
        for (int i = 0; i < CHANNELS; i++) begin
            sum = sum + SW'(warn_d[i] & ~warn_q[i]);
        end
        event_count_d = (sum > SAT) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Global flag and event counter registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            any_warn_q    <= 1'b0;
            event_count_q <= '0;
        end else begin
            any_warn_q    <= any_warn_d;
            event_count_q <= event_count_d;
        end
    end

    assign warn        = warn_q;
    assign any_warn    = any_warn_q;
    assign event_count = event_count_q;
endmodule

// File: tb/tb_warn_sensor_array.sv
// Bench for warn_sensor_array: directed scenarios plus random traffic, all
// compared against a run-length reference model. A second instance with a
// 2-bit event counter shares every input to exercise saturation.
`timescale 1ns/1ps
module tb_warn_sensor_array;
    localparam int W = 32;
    localparam int C = 4;
    localparam int D = 4;
    localparam int H = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [C*W-1:0]   sensor, threshold;
    logic [C-1:0]     mode, latch_en, ack;
    logic [C-1:0]     warn_a, warn_b;
    logic             any_a, any_b;
    logic [15:0]      ev_a;
    logic [1:0]       ev_b;

    int checks = 0;
    int errors = 0;

    // reference model: consecutive-sample run lengths per channel
    int  badrun[C];
    int  clrrun[C];
    bit  mw[C];
    bit  mh[C];
    int  rises;

    always #5 clock = ~clock;

    warn_sensor_array #(.WIDTH(W), .CHANNELS(C), .DEBOUNCE(D), .HYST(H), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset), .sensor(sensor), .threshold(threshold),
        .mode(mode), .latch_en(latch_en), .ack(ack),
        .warn(warn_a), .any_warn(any_a), .event_count(ev_a));

    warn_sensor_array #(.WIDTH(W), .CHANNELS(C), .DEBOUNCE(D), .HYST(H), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .sensor(sensor), .threshold(threshold),
        .mode(mode), .latch_en(latch_en), .ack(ack),
        .warn(warn_b), .any_warn(any_b), .event_count(ev_b));

    wire [27:0] act = {warn_a, any_a, ev_a, warn_b, any_b, ev_b};

    task automatic model_step();
        if (!reset) begin
            for (int i = 0; i < C; i++) begin
                badrun[i] = 0; clrrun[i] = 0; mw[i] = 0; mh[i] = 0;
            end
            rises = 0;
        end else begin
            for (int i = 0; i < C; i++) begin
                longint s, t;
                bit bad, clr;
                s   = longint'($signed(sensor[i*W +: W]));
                t   = longint'($signed(threshold[i*W +: W]));
                bad = mode[i] ? (s > t) : (s < t);
                clr = mode[i] ? (s <= t - H) : (s >= t + H);
                if (!mw[i]) begin
                    badrun[i] = bad ? badrun[i] + 1 : 0;
                    if (badrun[i] == D) begin
                        mw[i] = 1; badrun[i] = 0; clrrun[i] = 0; rises++;
                    end
                end else if (mh[i]) begin
                    if (ack[i]) begin
                        mh[i] = 0;
                        if (clr) mw[i] = 0;
                    end
                end else begin
                    clrrun[i] = clr ? clrrun[i] + 1 : 0;
                    if (clrrun[i] == D) begin
                        clrrun[i] = 0;
                        if (latch_en[i]) mh[i] = 1;
                        else mw[i] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [27:0] expv();
        logic [C-1:0] wv;
        int e16, e2;
        for (int i = 0; i < C; i++) wv[i] = mw[i];
        e16 = (rises > 65535) ? 65535 : rises;
        e2  = (rises > 3) ? 3 : rises;
        return {wv, |wv, 16'(e16), wv, |wv, 2'(e2)};
    endfunction

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] s, input logic [W-1:0] t, input logic m);
        sensor[ch*W +: W]    = s;
        threshold[ch*W +: W] = t;
        mode[ch]             = m;
    endtask

    // all channels parked inside the band: never bad, never clear
    task automatic set_idle();
        sensor = '0; threshold = '0; mode = '0; latch_en = '0; ack = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        set_idle();
        set_ch(0, 0, 10, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL reset_model cyc %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if (warn_a !== 4'b0 || any_a !== 1'b0 || ev_a !== 16'd0) begin
                errors++; $display("FAIL reset_hold cyc %0d: warn=%b any=%b ev=%0d want 0/0/0", i, warn_a, any_a, ev_a);
            end
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL reset_release_model cyc %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if (warn_a[0] !== (i == 3)) begin
                errors++; $display("FAIL reset_release_latency cyc %0d: warn0=%b want %b", i, warn_a[0], (i == 3));
            end
        end
        checks++;
        if (ev_a !== 16'd1 || any_a !== 1'b1) begin
            errors++; $display("FAIL reset_release_count: ev=%0d any=%b want 1/1", ev_a, any_a);
        end
    endtask

    task automatic test_debounce_glitch();
        int seq[8] = '{9, 9, 9, 10, 9, 9, 9, 9};
        set_idle();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_ch(0, seq[i], 10, 1'b0);
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL glitch_model step %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if (warn_a[0] !== (i == 7)) begin
                errors++; $display("FAIL glitch_warn step %0d: warn0=%b want %b", i, warn_a[0], (i == 7));
            end
        end
        checks++;
        if (ev_a !== 16'd1) begin
            errors++; $display("FAIL glitch_count: ev=%0d want 1", ev_a);
        end
    endtask

    task automatic test_hysteresis();
        set_idle();
        do_reset();
        for (int i = 0; i < 18; i++) begin
            int s;
            logic want;
            s    = (i < 4) ? 101 : (i < 14) ? 99 : 98;
            want = (i >= 3) && (i < 17);
            set_ch(1, s, 100, 1'b1);
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL hyst_model step %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if (warn_a[1] !== want) begin
                errors++; $display("FAIL hyst_warn step %0d: warn1=%b want %b", i, warn_a[1], want);
            end
        end
    endtask

    task automatic test_latching();
        // sensor, ack, expected warn[2] after the edge
        int   s_tab[14] = '{5, 5, 5, 5, 20, 20, 20, 20, 5, 20, 20, 20, 20, 20};
        logic a_tab[14] = '{0, 0, 0, 0, 0,  0,  0,  0,  1, 0,  1,  0,  0,  1};
        logic w_tab[14] = '{0, 0, 0, 1, 1,  1,  1,  1,  1, 1,  1,  1,  1,  0};
        set_idle();
        do_reset();
        latch_en[2] = 1'b1;
        for (int i = 0; i < 14; i++) begin
            set_ch(2, s_tab[i], 10, 1'b0);
            ack[2] = a_tab[i];
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL latch_model step %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if (warn_a[2] !== w_tab[i]) begin
                errors++; $display("FAIL latch_warn step %0d: warn2=%b want %b", i, warn_a[2], w_tab[i]);
            end
        end
        ack = '0;
        checks++;
        if (ev_a !== 16'd1) begin
            errors++; $display("FAIL latch_count: ev=%0d want 1", ev_a);
        end
    endtask

    task automatic test_simultaneous_extremes();
        logic [15:0] ev0;
        set_idle();
        do_reset();
        ev0 = ev_a;
        set_ch(0, 32'h8000_0000, 32'h7fff_ffff, 1'b0);
        set_ch(3, 32'h7fff_ffff, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL extreme_model step %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if ({warn_a[3], warn_a[0]} !== ((i == 3) ? 2'b11 : 2'b00)) begin
                errors++; $display("FAIL extreme_assert step %0d: warn=%b", i, warn_a);
            end
        end
        checks++;
        if (ev_a !== ev0 + 16'd2) begin
            errors++; $display("FAIL extreme_count: ev=%0d want %0d", ev_a, ev0 + 16'd2);
        end
        // sit at the far rail: threshold +/- HYST must not wrap into clear
        set_ch(0, 32'h7fff_ffff, 32'h7fff_ffff, 1'b0);
        set_ch(3, 32'h8000_0000, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL extreme_rail_model step %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if ({warn_a[3], warn_a[0]} !== 2'b11) begin
                errors++; $display("FAIL extreme_rail_hold step %0d: warn=%b want both set", i, warn_a);
            end
        end
    endtask

    task automatic test_saturation();
        set_idle();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) begin
                set_ch(0, (i < 4) ? 5 : 20, 10, 1'b0);
                tick();
                checks++;
                if (act !== expv()) begin
                    errors++; $display("FAIL sat_model toggle %0d step %0d: got %h want %h", k, i, act, expv());
                end
            end
        end
        checks++;
        if (ev_b !== 2'd3 || ev_a !== 16'd5) begin
            errors++; $display("FAIL sat_count: ev2=%0d ev16=%0d want 3/5", ev_b, ev_a);
        end
        // reset in the middle of PEND
        set_ch(0, 5, 10, 1'b0);
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++;
        if (warn_a !== 4'b0 || ev_a !== 16'd0 || ev_b !== 2'd0) begin
            errors++; $display("FAIL sat_reset_pend: warn=%b ev16=%0d ev2=%0d want 0", warn_a, ev_a, ev_b);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL sat_after_reset_model step %0d: got %h want %h", i, act, expv());
            end
            checks++;
            if (warn_a[0] !== (i == 3)) begin
                errors++; $display("FAIL sat_after_reset_warn step %0d: warn0=%b want %b", i, warn_a[0], (i == 3));
            end
        end
        // reset while warning: warn drops, nothing counted
        reset = 1'b0;
        tick();
        checks++;
        if (warn_a !== 4'b0 || any_a !== 1'b0 || ev_a !== 16'd0) begin
            errors++; $display("FAIL sat_reset_warn: warn=%b any=%b ev=%0d want 0", warn_a, any_a, ev_a);
        end
        reset = 1'b1;
    endtask

    task automatic test_random();
        int rthr[C];
        set_idle();
        do_reset();
        for (int i = 0; i < C; i++) rthr[i] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < C; ch++) begin
                if ($urandom_range(0, 49) == 0) rthr[ch] = int'($urandom_range(0, 16)) - 8;
                if ($urandom_range(0, 49) == 0) mode[ch] = ~mode[ch];
                if ($urandom_range(0, 19) == 0) latch_en[ch] = ~latch_en[ch];
                threshold[ch*W +: W] = rthr[ch];
                if ($urandom_range(0, 9) < 3)
                    sensor[ch*W +: W] = rthr[ch] + int'($urandom_range(0, 10)) - 5;
                ack[ch] = ($urandom_range(0, 3) == 0);
            end
            reset = ($urandom_range(0, 299) != 0);
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL random cyc %0d: got %h want %h", cyc, act, expv());
            end
        end
        reset = 1'b1;
        ack   = '0;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_debounce_glitch();
        test_hysteresis();
        test_latching();
        test_simultaneous_extremes();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/warn_sensor_array.md
# warn_sensor_array

Parametrised multi-channel successor to the single-channel engine-oil warning block. Monitors CHANNELS signed sensor readings against per-channel thresholds, each configurable as low-limit or high-limit. Per channel: debounced assertion, hysteresis-based release and optional latching until acknowledged. Sits between the sensor sampling front end and the dashboard/alarm logic, and also drives a global any-warning flag and a saturating warning-event counter.

## Interface

- WIDTH, 32: bit width of each signed sensor reading and threshold.
- CHANNELS, 4: number of independent monitored channels.
- DEBOUNCE, 4: consecutive samples required to assert or release a warning (≥1).
- HYST, 2: hysteresis band magnitude, unsigned, in sensor LSBs.
- CNT_W, 16: width of the warning-event counter.

- clock  in  1  rising-edge system clock.
- reset  in  1  synchronous, active-low reset.
- sensor  in  CHANNELS*WIDTH  packed signed readings; channel i at bits [i*WIDTH +: WIDTH].
- threshold  in  CHANNELS*WIDTH  packed signed limits, same packing.
- mode  in  CHANNELS  per channel: 0 = warn below threshold, 1 = warn above threshold.
- latch_en  in  CHANNELS  per channel: 1 = warning held until acknowledged.
- ack  in  CHANNELS  per-channel acknowledge pulse, level-sampled each edge.
- warn  out  CHANNELS  per-channel registered warning.
- any_warn  out  1  registered OR of all warn bits.
- event_count  out  CNT_W  saturating count of warn 0→1 transitions, all channels.

## Operation

- Conditions per channel, evaluated every edge in WIDTH+2-bit signed arithmetic, so no overflow at the extremes:
  - bad (mode 0): sensor < threshold. bad (mode 1): sensor > threshold.
  - clear (mode 0): sensor ≥ threshold + HYST. clear (mode 1): sensor ≤ threshold − HYST.
  - Readings inside the band are neither bad nor clear.
- Per-channel FSM with a debounce counter of width clog2(DEBOUNCE+1):
  - OK: warn=0, cnt=0. If bad: cnt=1; if DEBOUNCE==1 go to WARN, else go to PEND.
  - PEND: warn=0. If bad: cnt+1; at cnt==DEBOUNCE go to WARN. If not bad: go to OK, cnt=0.
  - WARN: warn=1, cnt=0. If clear: cnt=1 and go to REL; if DEBOUNCE==1, apply the release rule immediately.
  - REL: warn=1. If clear: cnt+1; at cnt==DEBOUNCE apply the release rule. If not clear: go back to WARN, cnt=0.
  - Release rule: if latch_en=0, go to OK. If latch_en=1, go to HOLD.
  - HOLD: warn=1, waiting for ack. On ack: go to OK if the current sample is clear, else go to WARN.
- ack is ignored in all states except HOLD.
- latch_en is sampled only at the moment the release rule is applied.
- mode and threshold changes take effect on the next evaluated sample. FSM state is not reset by a mode or threshold change.
- any_warn is computed from next-state warn values, so it changes on the same edge as warn.
- event_count increments by the number of channels whose warn goes 0→1 on that edge. It saturates at 2^CNT_W−1.

## Timing

- Reset, synchronous and active-low, is sampled on the rising edge. Result: all FSMs in OK, counters 0, warn=0, any_warn=0, event_count=0.
- Reset mid-PEND or mid-WARN aborts immediately. warn drops on the reset edge, and the count of that edge is not taken.
- Assert latency: bad first sampled at edge k → warn=1 after edge k+DEBOUNCE−1.
- Release latency (unlatched): clear first sampled at edge k → warn=0 after edge k+DEBOUNCE−1.
- Latched: warn=0 after the first edge at which the channel is in HOLD and ack=1 and the sample is clear.
- A single non-bad sample during PEND restarts debounce from zero. A single non-clear sample during REL does the same.
- Channels are fully independent. Simultaneous assertions on multiple channels in one edge each count.

## Test plan

- Reset and hold: reset=0 for 15 cycles with sensor 0 and threshold 10, mode 0 → warn=0, any_warn=0, event_count=0 throughout. Release reset → warn asserts 4 cycles later.
- Debounce glitch, ch0, mode 0, threshold 10: sensor 9 for 3 cycles, then 10, then 9 for 4 cycles → no warn during the glitch. warn[0]=1 after the 4th consecutive 9. event_count=1.
- Hysteresis, ch1, mode 1, threshold 100, HYST 2: sensor 101 for 4 cycles → warn. Then 99 for 10 cycles → warn stays 1. Then 98 for 4 cycles → warn[1]=0.
- Latching, ch2, latch_en=1, mode 0: warn, then sensor clear for 4 cycles → warn stays 1. ack while sensor 5 (bad) → warn stays, state WARN. ack after clear debounce → warn=0 the edge after ack.
- Simultaneous plus extremes: ch0 sensor −2^31 with threshold 2^31−1 in mode 0, and ch3 sensor 2^31−1 with threshold −2^31 in mode 1, both for 4 cycles → both warn on the same edge, event_count +2, no overflow.
- Saturation with CNT_W=2: toggle ch0 warn 5 times → event_count stops at 3. Assert reset mid-PEND → cnt cleared, no warn.
